// File: rtl/alloc_arbiter.sv
// alloc_arbiter: shares one linked-memory allocator between two requesters.
// Round-robin grant per cycle, one-stage response pipeline, per-port ack.
// Optional per-port allocation quota, built when ALLOC_ARB_QUOTA_EN is defined.
module alloc_arbiter #(
    parameter int QUOTA = 16,
    parameter int CW    = 5
) (
    input  logic        i_clk,
    input  logic        i_rst,
    // requester A
    input  logic        i_req_a,
    input  logic [1:0]  i_op_a,
    input  logic [15:0] i_addr_a,
    input  logic [15:0] i_data_a,
    output logic        o_gnt_a,
    output logic        o_ack_a,
    // requester B
    input  logic        i_req_b,
    input  logic [1:0]  i_op_b,
    input  logic [15:0] i_addr_b,
    input  logic [15:0] i_data_b,
    output logic        o_gnt_b,
    output logic        o_ack_b,
    // shared response
    output logic        o_err,
    output logic [15:0] o_result,
    // allocator alloc port
    output logic        o_al,
    output logic [15:0] o_adata,
    input  logic [15:0] i_aaddr,
    // allocator free port
    output logic        o_fr,
    output logic [15:0] o_faddr,
    // allocator write port
    output logic        o_wr,
    output logic [15:0] o_waddr,
    output logic [15:0] o_wdata,
    // allocator read port
    output logic        o_rd,
    output logic [15:0] o_raddr,
    input  logic [15:0] i_rdata
);

    localparam logic [1:0] OP_RD = 2'b00;
    localparam logic [1:0] OP_WR = 2'b01;
    localparam logic [1:0] OP_AL = 2'b10;
    localparam logic [1:0] OP_FR = 2'b11;

    // The counters must be able to hold QUOTA itself.
    if (QUOTA < 0 || (2 ** CW) <= QUOTA) begin : g_bad_cfg
        $error("alloc_arbiter: CW too narrow for QUOTA");
    end

    logic        prio;      // 0 = A wins a tie, 1 = B wins a tie
    logic        gnt_a;
    logic        gnt_b;
    logic        gnt;
    logic        sel_b;     // granted port (only meaningful when gnt)
    logic [1:0]  op;
    logic [15:0] addr;
    logic [15:0] data;
    logic        reject;    // granted op refused by quota
    logic        issue;     // granted op forwarded to the allocator

    // response pipeline stage
    logic        vld_q;
    logic        port_q;
    logic [1:0]  op_q;
    logic        err_q;
    logic        live;

    // Round-robin arbitration; grants are held low while in reset.
    always_comb begin
        gnt_a = !i_rst && i_req_a && (!i_req_b || !prio);
        gnt_b = !i_rst && i_req_b && (!i_req_a ||  prio);
    end

    assign gnt     = gnt_a || gnt_b;
    assign sel_b   = gnt_b;
    assign o_gnt_a = gnt_a;
    assign o_gnt_b = gnt_b;

    // Mux the granted port's operation fields.
    always_comb begin
        op   = sel_b ? i_op_b   : i_op_a;
        addr = sel_b ? i_addr_b : i_addr_a;
        data = sel_b ? i_data_b : i_data_a;
    end

`ifdef ALLOC_ARB_QUOTA_EN
    logic [CW-1:0] cnt_a;
    logic [CW-1:0] cnt_b;
    logic [CW-1:0] cnt_sel;

    // Refuse an alloc at the quota ceiling or a free with nothing held.
    always_comb begin
        cnt_sel = sel_b ? cnt_b : cnt_a;
        reject  = gnt && (((op == OP_AL) && (cnt_sel == CW'(QUOTA))) ||
                          ((op == OP_FR) && (cnt_sel == '0)));
    end

    // Track cells held per port; updated at the grant edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else if (issue) begin
            if (op == OP_AL) begin
                if (sel_b) cnt_b <= cnt_b + 1'b1;
                else       cnt_a <= cnt_a + 1'b1;
            end else if (op == OP_FR) begin
                if (sel_b) cnt_b <= cnt_b - 1'b1;
                else       cnt_a <= cnt_a - 1'b1;
            end
        end
    end
`else
    assign reject = 1'b0;
`endif

    assign issue = gnt && !reject;

    // Drive exactly one allocator strobe for a forwarded op; idle fields stay zero.
    always_comb begin
        o_rd    = 1'b0;
        o_raddr = 16'h0000;
        o_wr    = 1'b0;
        o_waddr = 16'h0000;
        o_wdata = 16'h0000;
        o_al    = 1'b0;
        o_adata = 16'h0000;
        o_fr    = 1'b0;
        o_faddr = 16'h0000;
        if (issue) begin
            case (op)
                OP_RD: begin
                    o_rd    = 1'b1;
                    o_raddr = addr;
                end
                OP_WR: begin
                    o_wr    = 1'b1;
                    o_waddr = addr;
                    o_wdata = data;
                end
                OP_AL: begin
                    o_al    = 1'b1;
                    o_adata = data;
                end
                default: begin
                    o_fr    = 1'b1;
                    o_faddr = addr;
                end
            endcase
        end
    end

    // Flip the tie-break pointer after every grant; hold it when idle.
    always_ff @(posedge i_clk) begin
        if (i_rst)    prio <= 1'b0;
        else if (gnt) prio <= !sel_b;
    end

    // Capture the granted op so its response lines up with allocator data.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vld_q  <= 1'b0;
            port_q <= 1'b0;
            op_q   <= OP_RD;
            err_q  <= 1'b0;
        end else begin
            vld_q  <= gnt;
            port_q <= sel_b;
            op_q   <= op;
            err_q  <= reject;
        end
    end

    // An op granted just before reset finishes at the allocator, but its ack
    // is swallowed while reset is high.
    assign live    = vld_q && !i_rst;
    assign o_ack_a = live && !port_q;
    assign o_ack_b = live &&  port_q;
    assign o_err   = live && err_q;

    // Result is only defined for a successful alloc or read.
    always_comb begin
        o_result = 16'h0000;
        if (live && !err_q) begin
            case (op_q)
                OP_AL:   o_result = i_aaddr;
                OP_RD:   o_result = i_rdata;
                default: o_result = 16'h0000;
            endcase
        end
    end

endmodule

// File: doc/alloc_arbiter.md
# alloc_arbiter

Two-port arbiter that shares one linked-memory allocator (`alloc`) between two requesters (A, B). Each requester issues read, write, alloc or free operations through a request/grant handshake. The arbiter picks one operation per cycle by round-robin, drives the allocator strobes, and returns the result with a per-port acknowledge. An optional per-port quota limits the number of cells each requester holds allocated.

## Interface
Parameters:
- `QUOTA`, 16: maximum cells a port may hold allocated (quota build only).
- `CW`, 5: width of the per-port allocation counters; must satisfy 2^CW > QUOTA.

Ports:
- `i_clk`  in  1  system clock; single clock domain.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_req_a` / `i_req_b`  in  1  operation request.
- `i_op_a` / `i_op_b`  in  2  operation code: 00 read, 01 write, 10 alloc, 11 free.
- `i_addr_a` / `i_addr_b`  in  16  address for read, write and free.
- `i_data_a` / `i_data_b`  in  16  data for write and alloc.
- `o_gnt_a` / `o_gnt_b`  out  1  request accepted this cycle (combinational).
- `o_ack_a` / `o_ack_b`  out  1  result valid (one-cycle pulse).
- `o_err`  out  1  qualifies an ack: operation rejected by quota.
- `o_result`  out  16  alloc address or read data; valid while an ack is high.
- `o_al`, `o_adata[15:0]`, `i_aaddr[15:0]`: allocator alloc port.
- `o_fr`, `o_faddr[15:0]`: allocator free port.
- `o_wr`, `o_waddr[15:0]`, `o_wdata[15:0]`: allocator write port.
- `o_rd`, `o_raddr[15:0]`, `i_rdata[15:0]`: allocator read port.

## Operation
- A requester raises `i_req_x` with `i_op_x`, `i_addr_x` and `i_data_x` stable. It holds all four until it samples `o_gnt_x` high at a rising edge.
- Arbitration (combinational):
  - Only one port requesting: that port is granted.
  - Both ports requesting: the port named by the priority pointer `prio` (0 = A, 1 = B) is granted.
  - After any grant, `prio` moves to the other port. `prio` does not change on idle cycles.
- Grant issue: in the grant cycle, exactly one allocator strobe (`o_rd`, `o_wr`, `o_al` or `o_fr`) is driven from the granted port's fields.
  - Read: `o_raddr = addr`.
  - Write: `o_waddr = addr`, `o_wdata = data`.
  - Alloc: `o_adata = data`.
  - Free: `o_faddr = addr`.
- All strobes are 0 when there is no grant or a quota rejection. Unused allocator address/data outputs are 16'h0000.
- Response pipeline register (one stage) holds `{valid, port, op, err}`.
- `o_result` selection, driven from the registered op:
  - Alloc: `i_aaddr`.
  - Read: `i_rdata`.
  - Write, free or error: 16'h0000 (UNDEF).
- Every granted operation is acked exactly once, including writes and frees.
- FSM: none beyond the pointer and pipeline. The block is fully pipelined with back-to-back grants every cycle.
- Simultaneous events:
  - An ack for the previous grant and a new grant may occur in the same cycle.
  - When the same port has both, its ack and grant are both high.

## Timing
- Grant to ack latency: exactly 1 cycle. Grant at edge T; `o_ack_x`, `o_result` and `o_err` are valid in cycle T+1.
- Throughput: 1 operation per cycle, aggregate across both ports.
- Starvation bound: with both ports requesting continuously, each port is granted every 2nd cycle.
- Reset (`i_rst` high at an edge):
  - `prio` = 0; pipeline valid = 0; counters = 0.
  - All `o_gnt_*`, allocator strobes, `o_ack_*` and `o_err` are 0; `o_result` is 16'h0000.
  - `o_gnt_*` are gated low combinationally while `i_rst` is high.
  - An operation granted in the cycle before reset still completes at the allocator, but its ack is suppressed.
  - Reset does not clear the allocator's memory or free list.

## Configuration
- `ALLOC_ARB_QUOTA_EN` defined: per-port counters `cnt_a` and `cnt_b` (CW bits) are built in.
  - A granted alloc with `cnt_x == QUOTA` is rejected: no `o_al`, ack with `o_err` = 1, `o_result` = 16'h0000.
  - A successful alloc increments `cnt_x`.
  - A free with `cnt_x == 0` is rejected the same way, with no `o_fr`.
  - A successful free decrements `cnt_x`.
  - Counters update at the grant edge.
- `ALLOC_ARB_QUOTA_EN` undefined: no counters and `QUOTA` is ignored. `o_err` is tied to 0 and every op is forwarded.

## Test plan
- Fresh allocator, A alloc(16'hFADE) → `o_gnt_a` same cycle, `o_al` = 1, `o_adata` = 16'hFADE; next cycle `o_ack_a` = 1, `o_result` = 16'h5000.
- A and B both request alloc continuously from `prio` = 0 → grants alternate A, B, A; acks return 16'h5000 (A), 16'h5001 (B), 16'h5002 (A).
- A write(16'h5034, 16'hD05E), then B read(16'h5034) → B ack with `o_result` = 16'hD05E, `o_err` = 0.
- Quota build, `QUOTA` = 2: A allocs three times → third ack has `o_err` = 1 and `o_result` = 16'h0000, with no `o_al` pulse; then A free(16'h5001) followed by A alloc → returns 16'h5001.
- Quota build: B free(16'h5000) immediately after reset → ack with `o_err` = 1 and no `o_fr`.
- `i_rst` asserted in the cycle after a grant → no ack; next cycle all outputs are 0 and the first grant after reset goes to A when both ports request.
